// File: rtl/sap1_fetch_unit.sv
// SAP-1 instruction-fetch unit: PC/MAR/IR ownership, memory strobe, valid/ready hand-off.
// Define SAP1_FETCH_HALT_EN to stop the unit after an accepted HLT (opcode 4'hF).
module sap1_fetch_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] mem_addr,
    output logic       mem_enable,
    input  logic [7:0] w_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] ir,
    output logic [3:0] opcode,
    output logic [3:0] operand,
    output logic [3:0] pc,
    input  logic       jmp_valid,
    input  logic [3:0] jmp_addr,
    output logic       halted,
    output logic [2:0] state_dbg
);

    // Handshake: an instruction transfers on any rising edge where instr_valid
    // and instr_ready are both high; while valid is high, ir stays stable.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        READ   = 3'd2,
        VALID  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] mar;
    logic       accept;
    logic       halt_take;

`ifdef SAP1_FETCH_HALT_EN
    logic halt_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pending <= 1'b0;
        end else if (state == READ) begin
            halt_pending <= (w_bus[7:4] == 4'hF);
        end
    end

    assign halt_take = halt_pending;
    assign halted    = (state == HALTED);
`else
    assign halt_take = 1'b0;
    assign halted    = 1'b0;
`endif

    assign accept = (state == VALID) && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ADDR;
            ADDR:    next_state = READ;
            READ:    next_state = VALID;
            VALID:   if (instr_ready) next_state = halt_take ? HALTED : ADDR;
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= 4'd0;
            mar <= 4'd0;
            ir  <= 8'd0;
        end else begin
            if (state == ADDR) begin
                mar <= pc;
            end
            if (state == READ) begin
                ir <= w_bus;
                pc <= pc + 4'd1;
            end
            // A jump overrides the increment taken at READ, except on a halting accept.
            if (accept && jmp_valid && !halt_take) begin
                pc <= jmp_addr;
            end
        end
    end

    assign mem_addr    = mar;
    assign mem_enable  = (state != READ);
    assign instr_valid = (state == VALID);
    assign opcode      = ir[7:4];
    assign operand     = ir[3:0];
    assign state_dbg   = state;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Directed bench for sap1_fetch_unit: per-cycle vector table plus reset and halt sequences.
// Follows SAP1_FETCH_HALT_EN for the halt sequence expectations.
module tb_sap1_fetch_unit;

    typedef struct {
        logic       start;
        logic       rdy;
        logic       jv;
        logic [3:0] ja;
        logic [3:0] addr;
        logic       en;
        logic       vld;
        logic [7:0] ir;
        logic [3:0] pc;
        logic       hlt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] mem_addr;
    logic       mem_enable;
    logic [7:0] w_bus;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] ir;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] pc;
    logic       jmp_valid;
    logic [3:0] jmp_addr;
    logic       halted;
    logic [2:0] state_dbg;

    logic [7:0] mem [16];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Combinational program memory; bus reads as 0 when released.
    assign w_bus = mem_enable ? 8'h00 : mem[mem_addr];

    sap1_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_enable  (mem_enable),
        .w_bus       (w_bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ir          (ir),
        .opcode      (opcode),
        .operand     (operand),
        .pc          (pc),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr),
        .halted      (halted),
        .state_dbg   (state_dbg)
    );

    function automatic vec_t mk(input logic s, input logic r, input logic jv, input logic [3:0] ja,
                                input logic [3:0] a, input logic e, input logic v,
                                input logic [7:0] i, input logic [3:0] p, input logic h);
        vec_t t;
        t.start = s; t.rdy = r; t.jv = jv; t.ja = ja;
        t.addr = a; t.en = e; t.vld = v; t.ir = i; t.pc = p; t.hlt = h;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check the outputs of the current cycle, advance one clock.
    task automatic apply_row(input string tag, input vec_t v);
        start       = v.start;
        instr_ready = v.rdy;
        jmp_valid   = v.jv;
        jmp_addr    = v.ja;
        #1;
        check({tag, ".mem_addr"},    {4'h0, mem_addr},    {4'h0, v.addr});
        check({tag, ".mem_enable"},  {7'h0, mem_enable},  {7'h0, v.en});
        check({tag, ".instr_valid"}, {7'h0, instr_valid}, {7'h0, v.vld});
        check({tag, ".ir"},          ir,                  v.ir);
        check({tag, ".opcode"},      {4'h0, opcode},      {4'h0, v.ir[7:4]});
        check({tag, ".operand"},     {4'h0, operand},     {4'h0, v.ir[3:0]});
        check({tag, ".pc"},          {4'h0, pc},          {4'h0, v.pc});
        check({tag, ".halted"},      {7'h0, halted},      {7'h0, v.hlt});
        @(negedge clk);
    endtask

    vec_t tbl [25];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {4'h5, 4'(i)};
        mem[0] = 8'h06; mem[1] = 8'h17; mem[2] = 8'h25; mem[3] = 8'hF0;
        mem[4] = 8'h34; mem[8] = 8'hE0; mem[15] = 8'h9A;

        //            st rdy jv ja     addr en vld ir     pc  hlt
        tbl[0]  = mk(0, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0); // idle
        tbl[1]  = mk(1, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0); // cycle 0: start
        tbl[2]  = mk(1, 0, 1, 4'h8, 4'h0, 1, 0, 8'h00, 4'h0, 0); // ADDR, start/jmp ignored
        tbl[3]  = mk(0, 0, 1, 4'h8, 4'h0, 0, 0, 8'h00, 4'h0, 0); // READ addr 0
        tbl[4]  = mk(0, 1, 0, 4'h0, 4'h0, 1, 1, 8'h06, 4'h1, 0); // VALID 0x06
        tbl[5]  = mk(1, 0, 1, 4'h8, 4'h0, 1, 0, 8'h06, 4'h1, 0); // ADDR
        tbl[6]  = mk(0, 0, 1, 4'h8, 4'h1, 0, 0, 8'h06, 4'h1, 0); // READ addr 1
        tbl[7]  = mk(0, 0, 0, 4'h0, 4'h1, 1, 1, 8'h17, 4'h2, 0); // VALID stalled
        tbl[8]  = mk(0, 0, 1, 4'h5, 4'h1, 1, 1, 8'h17, 4'h2, 0);
        tbl[9]  = mk(1, 0, 0, 4'h0, 4'h1, 1, 1, 8'h17, 4'h2, 0);
        tbl[10] = mk(0, 0, 1, 4'h9, 4'h1, 1, 1, 8'h17, 4'h2, 0);
        tbl[11] = mk(0, 0, 0, 4'h0, 4'h1, 1, 1, 8'h17, 4'h2, 0);
        tbl[12] = mk(0, 1, 0, 4'h0, 4'h1, 1, 1, 8'h17, 4'h2, 0); // accept
        tbl[13] = mk(0, 0, 0, 4'h0, 4'h1, 1, 0, 8'h17, 4'h2, 0); // ADDR
        tbl[14] = mk(0, 0, 0, 4'h0, 4'h2, 0, 0, 8'h17, 4'h2, 0); // READ addr 2
        tbl[15] = mk(0, 1, 1, 4'h8, 4'h2, 1, 1, 8'h25, 4'h3, 0); // accept + jump 8
        tbl[16] = mk(0, 0, 0, 4'h0, 4'h2, 1, 0, 8'h25, 4'h8, 0);
        tbl[17] = mk(0, 0, 0, 4'h0, 4'h8, 0, 0, 8'h25, 4'h8, 0); // READ addr 8
        tbl[18] = mk(0, 1, 1, 4'hF, 4'h8, 1, 1, 8'hE0, 4'h9, 0); // accept + jump 15
        tbl[19] = mk(0, 0, 0, 4'h0, 4'h8, 1, 0, 8'hE0, 4'hF, 0);
        tbl[20] = mk(0, 0, 0, 4'h0, 4'hF, 0, 0, 8'hE0, 4'hF, 0); // READ addr 15
        tbl[21] = mk(0, 1, 0, 4'h0, 4'hF, 1, 1, 8'h9A, 4'h0, 0); // pc wrapped
        tbl[22] = mk(0, 0, 0, 4'h0, 4'hF, 1, 0, 8'h9A, 4'h0, 0);
        tbl[23] = mk(0, 0, 0, 4'h0, 4'h0, 0, 0, 8'h9A, 4'h0, 0); // READ addr 0
        tbl[24] = mk(0, 0, 0, 4'h0, 4'h0, 1, 1, 8'h06, 4'h1, 0);

        rst_n = 1'b0; start = 0; instr_ready = 0; jmp_valid = 0; jmp_addr = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset.state", {5'h0, state_dbg}, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) apply_row($sformatf("row%0d", i), tbl[i]);

        // Asynchronous reset while the memory bus is driven.
        apply_row("pre_rst.valid", mk(0, 1, 0, 4'h0, 4'h0, 1, 1, 8'h06, 4'h1, 0));
        apply_row("pre_rst.addr",  mk(0, 0, 0, 4'h0, 4'h0, 1, 0, 8'h06, 4'h1, 0));
        check("pre_rst.read_en", {7'h0, mem_enable}, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("rst.mem_enable",  {7'h0, mem_enable},  8'h01);
        check("rst.instr_valid", {7'h0, instr_valid}, 8'h00);
        check("rst.pc",          {4'h0, pc},          8'h00);
        check("rst.ir",          ir,                  8'h00);
        check("rst.mem_addr",    {4'h0, mem_addr},    8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        apply_row("post_rst.idle", mk(0, 1, 1, 4'h7, 4'h0, 1, 0, 8'h00, 4'h0, 0));
        check("post_rst.state", {5'h0, state_dbg}, 8'h00);

        // Fetch address 3 (0xF0) via a jump, then accept it.
        apply_row("h.start", mk(1, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0));
        apply_row("h.addr0", mk(0, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0));
        apply_row("h.read0", mk(0, 0, 0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0));
        apply_row("h.jmp3",  mk(0, 1, 1, 4'h3, 4'h0, 1, 1, 8'h06, 4'h1, 0));
        apply_row("h.addr3", mk(0, 0, 0, 4'h0, 4'h0, 1, 0, 8'h06, 4'h3, 0));
        apply_row("h.read3", mk(0, 0, 0, 4'h0, 4'h3, 0, 0, 8'h06, 4'h3, 0));
`ifdef SAP1_FETCH_HALT_EN
        apply_row("h.hlt_acc", mk(0, 1, 1, 4'h8, 4'h3, 1, 1, 8'hF0, 4'h4, 0));
        for (int i = 0; i < 4; i++)
            apply_row($sformatf("h.halted%0d", i), mk(1, 1, 1, 4'h8, 4'h3, 1, 0, 8'hF0, 4'h4, 1));
`else
        apply_row("h.f0_acc", mk(0, 1, 0, 4'h0, 4'h3, 1, 1, 8'hF0, 4'h4, 0));
        apply_row("h.addr4",  mk(0, 0, 0, 4'h0, 4'h3, 1, 0, 8'hF0, 4'h4, 0));
        apply_row("h.read4",  mk(0, 0, 0, 4'h0, 4'h4, 0, 0, 8'hF0, 4'h4, 0));
        apply_row("h.valid4", mk(0, 0, 0, 4'h0, 4'h4, 1, 1, 8'h34, 4'h5, 0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
